// File: rtl/uart_pkg.sv
// uart_pkg: UART state encodings, tick constants and vote helper shared by uart_rx_os and uart_tx
package uart_pkg;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam int START_MID = 7;
  localparam int LAST_TICK = 15;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop rx synchroniser plus bit decision; UART_RX_MAJORITY_EN selects a 3-tick vote
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic s_tick,
  output logic rxs,
  output logic bit_val
);
  logic rx_meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {rxs, rx_meta} <= 2'b11;
    else {rxs, rx_meta} <= {rx_meta, rx};
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  // samples from the two previous s_ticks; with the live rxs they cover s-2..s at the deciding tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hist <= 2'b11;
    else if (s_tick) hist <= {hist[0], rxs};
  assign bit_val = maj3(hist[1], hist[0], rxs);
`else
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
  assign bit_val = rxs;
`endif
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled UART receiver with 1-entry valid/ready buffer; optional UART_RX_MAJORITY_EN voting
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       overrun_tick
);
  logic       rxs, bit_val;
  logic [1:0] state;
  logic [4:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic       stop_end, good, load;
  uart_rx_sampler u_smp (
    .clk    (clk),
    .reset_n(reset_n),
    .rx     (rx),
    .s_tick (s_tick),
    .rxs    (rxs),
    .bit_val(bit_val)
  );
  // tick counter is 5 bits so 1.5 and 2 stop-bit settings (24/32 ticks) fit
  assign stop_end = state == STOP && s_tick && s == 5'(SB_TICK - 1);
  assign good     = stop_end & bit_val;
  assign load     = good & (!rx_valid | rx_ready);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else case (state)
      IDLE:
        if (!rxs) begin
          state <= START;
          s     <= '0;
        end
      START:
        if (s_tick) begin
          if (s == 5'(START_MID)) begin
            state <= rxs ? IDLE : DATA;
            s     <= '0;
            n     <= '0;
          end else s <= s + 5'd1;
        end
      DATA:
        if (s_tick) begin
          if (s == 5'(LAST_TICK)) begin
            b     <= {bit_val, b[7:1]};
            s     <= '0;
            state <= n == 3'(DBIT - 1) ? STOP : DATA;
            n     <= n == 3'(DBIT - 1) ? n : n + 3'd1;
          end else s <= s + 5'd1;
        end
      default:
        if (s_tick) begin
          state <= s == 5'(SB_TICK - 1) ? IDLE : STOP;
          s     <= s == 5'(SB_TICK - 1) ? '0 : s + 5'd1;
        end
    endcase
  // a full buffer only refuses the new byte when the consumer is not taking the old one this cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun_tick <= 1'b0;
    end else begin
      dout         <= load ? b >> (8 - DBIT) : dout;
      rx_valid     <= load | (rx_valid & !rx_ready);
      rx_done_tick <= load;
      frame_err    <= stop_end & !bit_val;
      overrun_tick <= good & rx_valid & !rx_ready;
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed vectors for uart_rx_os, s_tick every 4 clk, DBIT=8, SB_TICK=16
module tb_uart_rx_os;
  logic       clk = 1'b0, reset_n = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_valid, rx_done_tick, frame_err, overrun_tick;
  logic [1:0] cnt = 2'd0;
  int n_chk = 0, n_fail = 0, n_done = 0, n_ferr = 0, n_ovr = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic [7:0] exp_dout;
    logic       exp_valid;
    int         exp_done;
    int         exp_ferr;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs[NV];

  uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .s_tick      (s_tick),
    .dout        (dout),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .overrun_tick(overrun_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 2'd1;
  assign s_tick = cnt == 2'd3;

  always @(negedge clk) begin
    if (rx_done_tick) n_done++;
    if (frame_err) n_ferr++;
    if (overrun_tick) n_ovr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int k);
    repeat (4 * k) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_done = 0;
    n_ferr = 0;
    n_ovr  = 0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // frame starts on the negedge before an s_tick edge; gbit/goff place a one-clk high glitch
  task automatic send(input logic [7:0] d, input logic stop, input int stop_len,
                      input bit rdy_at_load, input int gbit, input int goff);
    @(negedge clk);
    while (cnt != 2'd3) @(negedge clk);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == gbit) begin
        repeat (goff) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rx = d[i];
        repeat (63 - goff) @(negedge clk);
      end else ticks(16);
    end
    rx = stop;
    if (rdy_at_load) begin
      ticks(8);
      consume();
      repeat (4 * stop_len - 33) @(negedge clk);
    end else ticks(stop_len);
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_glitch;
    vecs[0] = '{8'h3C, 1'b0, 8'h00, 1'b0, 0, 1};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 8'h01, 1'b0, 0, 1};
    vecs[6] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1, 0};
    repeat (3) @(negedge clk);
    chk("reset dout", dout, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset pulses", {rx_done_tick, frame_err, overrun_tick}, 3'b000);
    reset_n = 1'b1;
    ticks(4);

    for (int i = 0; i < NV; i++) begin
      clear_counts();
      send(vecs[i].data, vecs[i].stop_ok, vecs[i].stop_ok ? 16 : 12, 1'b0, -1, 0);
      ticks(4);
      chk($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d done", i), n_done, vecs[i].exp_done);
      chk($sformatf("vec%0d frame_err", i), n_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d overrun", i), n_ovr, 0);
      ticks(8);
      chk($sformatf("vec%0d hold", i), rx_valid, vecs[i].exp_valid);
      consume();
      chk($sformatf("vec%0d consumed", i), rx_valid, 1'b0);
    end

    clear_counts();
    @(negedge clk);
    while (cnt != 2'd3) @(negedge clk);
    rx = 1'b0;
    ticks(5);
    rx = 1'b1;
    ticks(20);
    chk("false start pulses", n_done + n_ferr + n_ovr, 0);
    chk("false start rx_valid", rx_valid, 1'b0);
    send(8'h55, 1'b1, 16, 1'b0, -1, 0);
    ticks(4);
    chk("after false start dout", dout, 8'h55);
    chk("after false start done", n_done, 1);
    consume();

    clear_counts();
    send(8'h11, 1'b1, 16, 1'b0, -1, 0);
    send(8'h22, 1'b1, 16, 1'b0, -1, 0);
    ticks(4);
    chk("overrun dout", dout, 8'h11);
    chk("overrun rx_valid", rx_valid, 1'b1);
    chk("overrun done", n_done, 1);
    chk("overrun tick", n_ovr, 1);
    consume();
    chk("overrun consumed", rx_valid, 1'b0);

    clear_counts();
    send(8'h11, 1'b1, 16, 1'b0, -1, 0);
    send(8'h22, 1'b1, 16, 1'b1, -1, 0);
    ticks(4);
    chk("load-cycle ready dout", dout, 8'h22);
    chk("load-cycle ready rx_valid", rx_valid, 1'b1);
    chk("load-cycle ready done", n_done, 2);
    chk("load-cycle ready overrun", n_ovr, 0);

    clear_counts();
    fork
      send(8'hFF, 1'b1, 16, 1'b0, -1, 0);
      begin
        repeat (4 + 64 + 192 + 32) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-frame reset dout", dout, 8'h00);
        chk("mid-frame reset rx_valid", rx_valid, 1'b0);
        reset_n = 1'b1;
      end
    join
    ticks(4);
    chk("mid-frame reset pulses", n_done + n_ferr + n_ovr, 0);
    send(8'h0F, 1'b1, 16, 1'b0, -1, 0);
    ticks(4);
    chk("post-reset dout", dout, 8'h0F);
    chk("post-reset done", n_done, 1);
    chk("post-reset frame_err", n_ferr, 0);
    consume();

    clear_counts();
    send(8'h00, 1'b1, 16, 1'b0, 3, 26);
    ticks(4);
    chk("glitch s14 dout", dout, 8'h00);
    chk("glitch s14 done", n_done, 1);
    consume();
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h00;
`else
    exp_glitch = 8'h08;
`endif
    send(8'h00, 1'b1, 16, 1'b0, 3, 30);
    ticks(4);
    chk("glitch s15 dout", dout, exp_glitch);
    chk("glitch s15 done", n_done, 2);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
